serial_subtractor_4_bit: RTL and testbench



---
 rtl/serial_subtractor_4_bit_if.sv | 24 ++
 rtl/serial_subtractor_4_bit.sv | 113 +++++++++++
 tb/tb_serial_subtractor_4_bit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_4_bit_if.sv
// Operand/result bundle for the bit-serial subtractor: start/done handshake,
// operands in, registered difference and borrow out.
interface serial_subtractor_4_bit_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_4_bit.sv
// Bit-serial a - b - bin: one full-subtractor cell plus a borrow flop, LSB first,
// WIDTH cycles per operation under a start/done handshake.
module serial_subtractor_4_bit #(
    parameter int unsigned WIDTH = 4
) (
    input logic                      clk,
    input logic                      rst,
    serial_subtractor_4_bit_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic             brw_q, brw_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             accept;
    logic             last_bit;
    logic             x, y, d_bit, brw_nxt;
    logic [WIDTH-1:0] d_sh_nxt;

    // start only matters when no operation is in flight
    assign accept   = bus_io.start && (state_q == StIdle || state_q == StDone);
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs
    assign x        = a_sh_q[0];
    assign y        = b_sh_q[0];
    assign d_bit    = x ^ y ^ brw_q;
    assign brw_nxt  = (~x & y) | (~(x ^ y) & brw_q);
    assign d_sh_nxt = (d_sh_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = accept ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only
    always_comb begin
        bus_io.busy = (state_q == StRun);
        bus_io.done = (state_q == StDone);
        bus_io.diff = diff_q;
        bus_io.bout = bout_q;
    end

    // Datapath next-state
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        d_sh_d = d_sh_q;
        brw_d  = brw_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        if (accept) begin
            a_sh_d = bus_io.a;
            b_sh_d = bus_io.b;
            brw_d  = bus_io.bin;
            cnt_d  = '0;
        end else if (state_q == StRun) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            d_sh_d = d_sh_nxt;
            brw_d  = brw_nxt;
            cnt_d  = cnt_q + 1'b1;
            if (last_bit) begin
                diff_d = d_sh_nxt;
                bout_d = brw_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            d_sh_q <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            d_sh_q <= d_sh_d;
            brw_q  <= brw_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor_4_bit.sv
// Self-checking bench for serial_subtractor_4_bit: directed table, handshake
// corner cases, then an exhaustive plus random back-to-back stream vs. a model.
module tb_serial_subtractor_4_bit;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    serial_subtractor_4_bit_if #(.WIDTH(W)) bus ();

    serial_subtractor_4_bit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
    } op_t;

    vec_t vecs[5];
    op_t  ops[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain 5-bit unsigned subtraction; bit 4 is the borrow
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic bin);
        return {1'b0, a} - {1'b0, b} - {4'b0, bin};
    endfunction

    task automatic drive(input logic st, input logic [3:0] a, input logic [3:0] b,
                         input logic bin);
        bus.start = st;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
    endtask

    // One isolated operation from IDLE/DONE, checking busy window and result
    task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic bin, input logic [3:0] ed, input logic eb);
        logic busy_ok;
        busy_ok = 1'b1;
        drive(1'b1, a, b, bin);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
            if (!(bus.busy === 1'b1 && bus.done === 1'b0)) busy_ok = 1'b0;
        end
        check({name, "_busy"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        check({name, "_done"}, {30'd0, bus.done, bus.busy}, 32'd2);
        check({name, "_diff"}, 32'(bus.diff), 32'(ed));
        check({name, "_bout"}, 32'(bus.bout), 32'(eb));
    endtask

    initial begin
        logic [4:0] r;
        logic [4:0] sum;
        int         cyc;
        bit         found;
        bit         done_seen;

        vecs[0] = '{4'd9,  4'd3, 1'b0, 4'b0110, 1'b0};
        vecs[1] = '{4'd3,  4'd9, 1'b0, 4'b1010, 1'b1};
        vecs[2] = '{4'd0,  4'd0, 1'b1, 4'b1111, 1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,   1'b0};
        vecs[4] = '{4'd15, 4'd0, 1'b1, 4'd14,   1'b0};

        drive(1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {28'd0, bus.busy, bus.done, bus.bout, 1'b0}, 32'd0);
        check("reset_diff", 32'(bus.diff), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            r = model(vecs[i].a, vecs[i].b, vecs[i].bin);
            check($sformatf("table%0d_model", i), 32'(r), {27'd0, vecs[i].exp_bout,
                  vecs[i].exp_diff});
            run_op($sformatf("table%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].exp_diff, vecs[i].exp_bout);
        end

        // Reset two cycles into an operation aborts it with no done pulse
        @(negedge clk);
        drive(1'b1, 4'd9, 4'd3, 1'b0);
        done_seen = 1'b0;
        @(negedge clk);
        drive(1'b0, 4'd9, 4'd3, 1'b0);
        done_seen |= bus.done;
        @(negedge clk);
        done_seen |= bus.done;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_bout", 32'(bus.bout), 32'd0);
        for (int i = 0; i < 6; i++) begin
            done_seen |= bus.done;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        run_op("after_rst", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);

        // start re-pulsed two cycles into RUN with other operands is ignored
        @(negedge clk);
        drive(1'b1, 4'd9, 4'd3, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'd1, 4'd2, 1'b1);
        @(negedge clk);
        drive(1'b1, 4'd1, 4'd2, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'd7, 4'd2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("ign_done", 32'(bus.done), 32'd1);
        check("ign_result", {27'd0, bus.bout, bus.diff}, 32'd6);
        @(negedge clk);
        check("ign_no_queue", {30'd0, bus.busy, bus.done}, 32'd0);

        // Exhaustive then random, back-to-back with start held in DONE
        for (int i = 0; i < 512; i++) ops.push_back('{4'(i >> 5), 4'(i >> 1), 1'(i)});
        for (int i = 0; i < 64; i++)
            ops.push_back('{4'($urandom), 4'($urandom), 1'($urandom)});

        @(negedge clk);
        drive(1'b1, ops[0].a, ops[0].b, ops[0].bin);
        for (int k = 0; k < ops.size(); k++) begin
            cyc   = 0;
            found = 1'b0;
            for (int c = 0; c < 12 && !found; c++) begin
                @(negedge clk);
                cyc++;
                if (bus.done === 1'b1) found = 1'b1;
                else drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            end
            if (!found) begin
                check($sformatf("stream%0d_timeout", k), 32'd0, 32'd1);
                break;
            end
            check($sformatf("stream%0d_interval", k), 32'(cyc), 32'd5);
            r = model(ops[k].a, ops[k].b, ops[k].bin);
            check($sformatf("stream%0d_result a=%0d b=%0d bin=%0d", k, ops[k].a, ops[k].b,
                  ops[k].bin), {27'd0, bus.bout, bus.diff}, 32'(r));
            // Adder recomputation: diff + b + bin == a + 16*bout
            sum = {1'b0, bus.diff} + {1'b0, ops[k].b} + {4'd0, ops[k].bin};
            check($sformatf("stream%0d_adder", k), {27'd0, sum}, {27'd0, bus.bout, ops[k].a});
            if (k + 1 < ops.size()) drive(1'b1, ops[k+1].a, ops[k+1].b, ops[k+1].bin);
            else drive(1'b0, 4'd0, 4'd0, 1'b0);
        end
        @(negedge clk);
        check("final_idle", {30'd0, bus.busy, bus.done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
